input_conditioner: RTL and testbench

- Parametrised successor to the fixed four-switch synchro/debnce/update chain in the top level. Conditions NUM_INPUTS asynchronous switches/buttons: synchronise, debounce, and optionally convert buttons to toggles.
- Produces one coalesced update request per burst of changes, with a changed-channel mask and a request/acknowledge handshake.
- Sits between board pins and consumers of configuration changes: the rendering engine and the port1 controller (resolution/update).

---
 rtl/input_conditioner_pkg.sv | 25 ++
 rtl/input_conditioner_debounce_channel.sv | 70 +++++++
 rtl/input_conditioner.sv | 117 +++++++++++
 tb/tb_input_conditioner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: FSM state encoding and
// helpers used to size counters from integer parameters.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    POWERUP = 2'd0,
    IDLE    = 2'd1,
    SETTLE  = 2'd2,
    REQ     = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while (((64'd1 << r) < 64'(value)) && (r < 32)) r++;
    return r;
  endfunction

  // Counter width able to hold value-1, never narrower than one bit.
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned channel: synchroniser chain, debounce counter, stable
// level, and the level/toggle output stage with its one-cycle edge pulse.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit TOGGLE          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic value,
  output logic edge_pulse
);

  localparam int CW = width_of(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   stable_reg;
  logic                   value_reg;
  logic                   edge_reg;
  logic                   sync_out;
  logic                   accept;
  logic                   fire;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  // A new level is accepted on the edge that completes the stable run.
  assign accept   = (sync_out != stable_reg) && (cnt_reg == CNT_LAST);
  // Toggle channels only react to an accepted rising level.
  assign fire     = TOGGLE ? (accept && sync_out) : accept;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
  end

  // Count consecutive mismatching cycles; accept the level at the terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (sync_out == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg    <= '0;
      stable_reg <= sync_out;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Update the output value and edge pulse on the same edge as the stable level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_reg <= 1'b0;
      edge_reg  <= 1'b0;
    end else begin
      edge_reg <= fire;
      if (fire) value_reg <= TOGGLE ? ~value_reg : sync_out;
    end
  end

  assign value      = value_reg;
  assign edge_pulse = edge_reg;

endmodule

// File: rtl/input_conditioner.sv
// Conditions NUM_INPUTS switches/buttons and coalesces bursts of changes
// into a single update request with a changed-channel mask and a
// request/acknowledge handshake.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int                    NUM_INPUTS      = 4,
  parameter int                    SYNC_STAGES     = 2,
  parameter int                    DEBOUNCE_CYCLES = 65536,
  parameter logic [NUM_INPUTS-1:0] TOGGLE_MASK     = '0,
  parameter int                    HOLDOFF_CYCLES  = 1024,
  parameter int                    PWRUP_CYCLES    = 16
) (
  input  logic                  clk,
  input  logic                  SYS_RESETn,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] value,
  output logic [NUM_INPUTS-1:0] edge_pulse,
  output logic                  update_req,
  input  logic                  update_ack,
  output logic [NUM_INPUTS-1:0] changed_mask
);

  localparam int PW = width_of(PWRUP_CYCLES);
  localparam int HW = width_of(HOLDOFF_CYCLES);
  localparam logic [PW-1:0] PWR_LAST  = PW'(PWRUP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  state_t                  state_reg;
  logic [PW-1:0]           pwr_cnt_reg;
  logic [HW-1:0]           hold_cnt_reg;
  logic [NUM_INPUTS-1:0]   acc_reg;
  logic [NUM_INPUTS-1:0]   acc_merged;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ch
      debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .TOGGLE          (TOGGLE_MASK[gi])
      ) u_ch (
        .clk        (clk),
        .rst_n      (SYS_RESETn),
        .raw        (raw_in[gi]),
        .value      (value[gi]),
        .edge_pulse (edge_pulse[gi])
      );
    end
  endgenerate

  assign acc_merged = acc_reg | edge_pulse;

  // Request FSM: power-up request, holdoff after the last change, then
  // hold the request and mask until acknowledged.
  always_ff @(posedge clk) begin
    if (!SYS_RESETn) begin
      state_reg    <= POWERUP;
      pwr_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      acc_reg      <= '0;
      update_req   <= 1'b0;
      changed_mask <= '0;
    end else begin
      case (state_reg)
        POWERUP: begin
          if (pwr_cnt_reg == PWR_LAST) begin
            // Anything that changed during power-up is covered by all-ones.
            state_reg    <= REQ;
            update_req   <= 1'b1;
            changed_mask <= '1;
            acc_reg      <= '0;
          end else begin
            pwr_cnt_reg <= pwr_cnt_reg + PW'(1);
            acc_reg     <= acc_merged;
          end
        end
        IDLE: begin
          acc_reg <= acc_merged;
          if (|edge_pulse) begin
            state_reg    <= SETTLE;
            hold_cnt_reg <= HOLD_LAST;
          end
        end
        SETTLE: begin
          if (|edge_pulse) begin
            hold_cnt_reg <= HOLD_LAST;
            acc_reg      <= acc_merged;
          end else if (hold_cnt_reg == '0) begin
            state_reg    <= REQ;
            update_req   <= 1'b1;
            changed_mask <= acc_reg;
            acc_reg      <= '0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg - HW'(1);
          end
        end
        REQ: begin
          // Changes seen while the request is held wait for the next request.
          acc_reg <= acc_merged;
          if (update_ack) begin
            update_req   <= 1'b0;
            changed_mask <= '0;
            if (|acc_merged) begin
              state_reg    <= SETTLE;
              hold_cnt_reg <= HOLD_LAST;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce/holdoff timing.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  logic       clk;
  logic       SYS_RESETn;
  logic [3:0] raw_in;
  logic [3:0] value;
  logic [3:0] edge_pulse;
  logic       update_req;
  logic       update_ack;
  logic [3:0] changed_mask;

  int n_checks = 0;
  int n_fail   = 0;

  input_conditioner #(
    .NUM_INPUTS      (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .TOGGLE_MASK     (4'b1000),
    .HOLDOFF_CYCLES  (16),
    .PWRUP_CYCLES    (32)
  ) dut (
    .clk          (clk),
    .SYS_RESETn   (SYS_RESETn),
    .raw_in       (raw_in),
    .value        (value),
    .edge_pulse   (edge_pulse),
    .update_req   (update_req),
    .update_ack   (update_ack),
    .changed_mask (changed_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_ack(input string tag);
    update_ack = 1'b1;
    tick(1);
    update_ack = 1'b0;
    check({tag, "_req_after_ack"}, 16'(update_req), 16'd0);
    check({tag, "_mask_after_ack"}, 16'(changed_mask), 16'd0);
  endtask

  // One press/release on the toggle channel; value[0] is 1 and value[1] is 0 here.
  task automatic toggle_cycle(input string tag, input logic exp_val);
    logic [3:0] seen;
    raw_in[3] = 1'b1;
    tick(10);
    check({tag, "_press_value"}, 16'(value), 16'({exp_val, 3'b001}));
    check({tag, "_press_edge"}, 16'(edge_pulse), 16'h8);
    tick(2);
    raw_in[3] = 1'b0;
    seen = '0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      seen |= edge_pulse;
    end
    check({tag, "_release_no_edge"}, 16'(seen), 16'h0);
    check({tag, "_release_value"}, 16'(value), 16'({exp_val, 3'b001}));
    check({tag, "_req_before"}, 16'(update_req), 16'd0);
    tick(1);
    check({tag, "_req"}, 16'(update_req), 16'd1);
    check({tag, "_mask"}, 16'(changed_mask), 16'h8);
    do_ack(tag);
  endtask

  initial begin
    logic [3:0] seen;
    SYS_RESETn = 1'b0;
    raw_in     = 4'h0;
    update_ack = 1'b0;

    // Step 1: reset and power-up request
    tick(3);
    check("rst_req", 16'(update_req), 16'd0);
    check("rst_value", 16'(value), 16'h0);
    check("rst_mask", 16'(changed_mask), 16'h0);
    check("rst_edge", 16'(edge_pulse), 16'h0);
    SYS_RESETn = 1'b1;
    tick(31);
    check("pwr_req_early", 16'(update_req), 16'd0);
    tick(1);
    check("pwr_req", 16'(update_req), 16'd1);
    check("pwr_mask", 16'(changed_mask), 16'hF);
    do_ack("pwr");
    check("pwr_state_idle", 16'(dut.state_reg), 16'(IDLE));
    check("pwr_value", 16'(value), 16'h0);
    $display("step 1 power-up request done");

    // Step 2: level channel 0 rise, latency and holdoff
    raw_in[0] = 1'b1;
    tick(9);
    check("ch0_value_early", 16'(value), 16'h0);
    check("ch0_edge_early", 16'(edge_pulse), 16'h0);
    tick(1);
    check("ch0_value", 16'(value), 16'h1);
    check("ch0_edge", 16'(edge_pulse), 16'h1);
    tick(1);
    check("ch0_edge_one_cycle", 16'(edge_pulse), 16'h0);
    tick(15);
    check("ch0_req_early", 16'(update_req), 16'd0);
    tick(1);
    check("ch0_req", 16'(update_req), 16'd1);
    check("ch0_mask", 16'(changed_mask), 16'h1);
    do_ack("ch0");
    $display("step 2 level rise request done");

    // Step 3: 7-cycle glitch is rejected, 8-cycle pulse is accepted
    raw_in[1] = 1'b1;
    seen = '0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      seen |= edge_pulse;
    end
    raw_in[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen |= edge_pulse;
    end
    check("glitch_no_edge", 16'(seen), 16'h0);
    check("glitch_value", 16'(value), 16'h1);
    check("glitch_state_idle", 16'(dut.state_reg), 16'(IDLE));
    raw_in[1] = 1'b1;
    tick(8);
    raw_in[1] = 1'b0;
    tick(2);
    check("pulse8_rise_value", 16'(value), 16'h3);
    check("pulse8_rise_edge", 16'(edge_pulse), 16'h2);
    tick(8);
    check("pulse8_fall_value", 16'(value), 16'h1);
    check("pulse8_fall_edge", 16'(edge_pulse), 16'h2);
    tick(16);
    check("pulse8_req_early", 16'(update_req), 16'd0);
    tick(1);
    check("pulse8_req", 16'(update_req), 16'd1);
    check("pulse8_mask", 16'(changed_mask), 16'h2);
    do_ack("pulse8");
    $display("step 3 glitch filter done");

    // Step 4: toggle channel, two press/release cycles
    toggle_cycle("tog1", 1'b1);
    toggle_cycle("tog2", 1'b0);
    $display("step 4 toggle done");

    // Step 5: change while request is held
    raw_in[0] = 1'b0;
    tick(27);
    check("held_req", 16'(update_req), 16'd1);
    check("held_mask", 16'(changed_mask), 16'h1);
    raw_in[2] = 1'b1;
    tick(10);
    check("held_req_kept", 16'(update_req), 16'd1);
    check("held_mask_kept", 16'(changed_mask), 16'h1);
    check("held_value", 16'(value), 16'h4);
    check("held_edge", 16'(edge_pulse), 16'h4);
    tick(3);
    update_ack = 1'b1;
    tick(1);
    update_ack = 1'b0;
    check("held_req_after_ack", 16'(update_req), 16'd0);
    check("held_mask_after_ack", 16'(changed_mask), 16'h0);
    check("held_state_settle", 16'(dut.state_reg), 16'(SETTLE));
    tick(15);
    check("second_req_early", 16'(update_req), 16'd0);
    tick(1);
    check("second_req", 16'(update_req), 16'd1);
    check("second_mask", 16'(changed_mask), 16'h4);
    $display("step 5 held-request accumulation done");

    // Step 6: reset pulse while in REQ
    SYS_RESETn = 1'b0;
    tick(1);
    check("midrst_req", 16'(update_req), 16'd0);
    check("midrst_value", 16'(value), 16'h0);
    check("midrst_mask", 16'(changed_mask), 16'h0);
    check("midrst_state", 16'(dut.state_reg), 16'(POWERUP));
    SYS_RESETn = 1'b1;
    tick(31);
    check("repwr_req_early", 16'(update_req), 16'd0);
    tick(1);
    check("repwr_req", 16'(update_req), 16'd1);
    check("repwr_mask", 16'(changed_mask), 16'hF);
    do_ack("repwr");
    check("repwr_state_idle", 16'(dut.state_reg), 16'(IDLE));
    check("repwr_value", 16'(value), 16'h4);
    $display("step 6 mid-request reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
